// File: rtl/reg_write_sequencer.sv
// Write-back sequencer feeding the 16x32 register bank: source mux, request FIFO,
// and a DRIVE/GAP drain FSM that pulses a one-hot enable with stable load data.
module reg_write_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [3:0]                 wr_addr,
  input  logic [1:0]                 wr_sel,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic [DATA_W-1:0]          imm_data,
  input  logic [DATA_W-1:0]          pc_data,
  input  logic                       hold,
  input  logic                       flush,
  output logic [15:0]                enable,
  output logic [DATA_W-1:0]          load_data,
  output logic [15:0]                pending,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]        state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [3:0]        addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [DATA_W-1:0] sel_data;
  logic              push;
  logic              start;
  logic [PW-1:0]     scan_idx;

  assign wr_ready = (level < LW'(DEPTH));

  // A push coinciding with flush is dropped so the queue comes out truly empty.
  assign push  = wr_valid && wr_ready && !flush;
  // A new drive may begin from IDLE or GAP only, which enforces the one-cycle gap.
  assign start = (level != '0) && !hold && !flush && (state != ST_DRIVE);

  // NOTE: every signal assigned in always_comb gets a default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    sel_data = alu_data;
    unique case (wr_sel)
      2'd0: sel_data = alu_data;
      2'd1: sel_data = mem_data;
      2'd2: sel_data = imm_data;
      2'd3: sel_data = pc_data;
      default: sel_data = alu_data;
    endcase
  end

  // NOTE: the FIFO storage has no reset; its contents are only read for slots that
  // level marks valid, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= wr_addr;
      data_mem[wr_ptr] <= sel_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (start) rd_ptr <= rd_ptr + 1'b1;
      if (push && !start)      level <= level + 1'b1;
      else if (!push && start) level <= level - 1'b1;
    end
  end

  // enable and load_data only change together when enable rises; the falling edge
  // of enable leaves load_data untouched, so the bank never sees a data glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      enable    <= '0;
      load_data <= '0;
    end else if (start) begin
      state     <= ST_DRIVE;
      enable    <= 16'(1) << addr_mem[rd_ptr];
      load_data <= data_mem[rd_ptr];
    end else begin
      state  <= (state == ST_DRIVE) ? ST_GAP : ST_IDLE;
      enable <= '0;
    end
  end

  // The in-drive entry is already popped, so its target is taken from enable itself.
  always_comb begin
    pending  = (state == ST_DRIVE) ? enable : '0;
    scan_idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PW'(i);
      if (LW'(i) < level) pending[addr_mem[scan_idx]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Self-checking bench for reg_write_sequencer: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_reg_write_sequencer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [3:0]        wr_addr = '0;
  logic [1:0]        wr_sel = '0;
  logic [DATA_W-1:0] alu_data = '0, mem_data = '0, imm_data = '0, pc_data = '0;
  logic              hold = 1'b0;
  logic              flush = 1'b0;
  logic [15:0]       enable;
  logic [DATA_W-1:0] load_data;
  logic [15:0]       pending;
  logic [2:0]        level;

  reg_write_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_sel(wr_sel), .alu_data(alu_data), .mem_data(mem_data),
    .imm_data(imm_data), .pc_data(pc_data), .hold(hold), .flush(flush),
    .enable(enable), .load_data(load_data), .pending(pending), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Reference model: the queue of accepted writes, whether the last edge started a
  // write, and the values the bank should currently see.
  entry_t            mq[$];
  bit                m_driving;
  logic [15:0]       m_en;
  logic [DATA_W-1:0] m_ld;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pending();
    logic [15:0] p;
    p = m_driving ? m_en : 16'h0;
    foreach (mq[i]) p[mq[i].addr] = 1'b1;
    return p;
  endfunction

  task automatic check_all();
    check("enable", 32'(enable), 32'(m_en));
    check("load_data", load_data, m_ld);
    check("level", 32'(level), mq.size());
    check("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
    check("pending", 32'(pending), 32'(model_pending()));
  endtask

  // One clock: the model consumes the inputs as they stand at the edge, then the DUT
  // is compared 1 time unit later.
  task automatic step();
    bit                start, take;
    logic [DATA_W-1:0] src;
    entry_t            e;
    @(posedge clk);
    start = (mq.size() > 0) && !hold && !flush && !m_driving;
    take  = wr_valid && (mq.size() < DEPTH) && !flush;
    case (wr_sel)
      2'd0: src = alu_data;
      2'd1: src = mem_data;
      2'd2: src = imm_data;
      default: src = pc_data;
    endcase
    if (start) begin
      e    = mq.pop_front();
      m_en = 16'h0;
      m_en[e.addr] = 1'b1;
      m_ld = e.data;
    end else begin
      m_en = 16'h0;
    end
    m_driving = start;
    if (flush) mq.delete();
    if (take) mq.push_back('{addr: wr_addr, data: src});
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_driving = 1'b0;
    m_en = 16'h0;
    m_ld = '0;
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic request(input logic [3:0] a, input logic [1:0] s, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_sel   = s;
    case (s)
      2'd0: alu_data = d;
      2'd1: mem_data = d;
      2'd2: imm_data = d;
      default: pc_data = d;
    endcase
  endtask

  logic [15:0] en_seq [7];
  logic [15:0] exp_seq [7];
  logic [31:0] accept_val;

  initial begin
    exp_seq = '{16'h0001, 16'h0000, 16'h0002, 16'h0000, 16'h0004, 16'h0000, 16'h0008};

    // Reset state
    apply_reset();
    check("reset_wr_ready", 32'(wr_ready), 32'd1);

    // Single write to R5 from mem_data
    request(4'd5, 2'd1, 32'hDEADBEEF);
    step();
    wr_valid = 1'b0;
    check("single_pending", 32'(pending), 32'h0020);
    step();
    check("single_enable", 32'(enable), 32'h0020);
    check("single_data", load_data, 32'hDEADBEEF);
    step();
    check("single_enable_low", 32'(enable), 32'h0);
    check("single_data_hold", load_data, 32'hDEADBEEF);
    check("single_pending_clr", 32'(pending), 32'h0);

    // Fill under hold, refuse a fifth, then drain in order
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      request(4'(i), 2'd0, 32'h100 + 32'(i));
      step();
    end
    check("full_level", 32'(level), 32'd4);
    check("full_ready", 32'(wr_ready), 32'd0);
    request(4'd9, 2'd0, 32'h999);
    step();
    check("full_refused", 32'(level), 32'd4);
    wr_valid = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      en_seq[i] = enable;
    end
    for (int i = 0; i < 7; i++) check($sformatf("drain_seq%0d", i), 32'(en_seq[i]), 32'(exp_seq[i]));

    // Two writes to R7: pending held until the second drive, data in order
    step();
    request(4'd7, 2'd2, 32'h11);
    step();
    request(4'd7, 2'd2, 32'h22);
    step();
    wr_valid = 1'b0;
    check("r7_first", load_data, 32'h11);
    step();
    check("r7_pending_gap", 32'(pending[7]), 32'd1);
    step();
    check("r7_second", load_data, 32'h22);
    check("r7_pending_drive", 32'(pending[7]), 32'd1);
    step();
    check("r7_pending_clr", 32'(pending[7]), 32'd0);

    // Sources sampled only at accept
    for (int s = 0; s < 4; s++) begin
      if (s == 1) continue;
      accept_val = 32'hA000_0000 + 32'(s * 16 + 3);
      request(4'(s + 10), 2'(s), accept_val);
      step();
      wr_valid = 1'b0;
      alu_data = $urandom; imm_data = $urandom; pc_data = $urandom;
      step();
      check($sformatf("sample_sel%0d", s), load_data, accept_val);
      step();
    end

    // Flush during the first drive
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      request(4'(i + 4), 2'd0, 32'h200 + 32'(i));
      step();
    end
    wr_valid = 1'b0;
    hold = 1'b0;
    step();
    check("flush_drive", 32'(enable), 32'h0010);
    flush = 1'b1;
    request(4'd15, 2'd0, 32'h5555);
    step();
    flush = 1'b0;
    wr_valid = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_pending", 32'(pending), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_pulse", 32'(enable), 32'h0);
    end

    // Reset in the middle of a drive with entries queued
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      request(4'(i + 12), 2'd3, 32'h300 + 32'(i));
      step();
    end
    wr_valid = 1'b0;
    hold = 1'b0;
    step();
    check("rst_pre_drive", 32'(enable), 32'h1000);
    apply_reset();
    check("rst_enable", 32'(enable), 32'h0);
    check("rst_level", 32'(level), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_no_pulse", 32'(enable), 32'h0);
    end

    // Randomized traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      wr_valid = ($urandom_range(0, 9) < 6);
      wr_addr  = 4'($urandom);
      wr_sel   = 2'($urandom);
      alu_data = $urandom; mem_data = $urandom; imm_data = $urandom; pc_data = $urandom;
      hold     = ($urandom_range(0, 9) < 3);
      flush    = ($urandom_range(0, 39) == 0);
      step();
    end
    wr_valid = 1'b0;
    hold = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("final_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_write_sequencer.md
# reg_write_sequencer

Write-back sequencer directly upstream of the 16×32 register bank. It selects the load value from one of four result sources and queues write requests in a small FIFO. It then drives the bank's one-hot `enable` and 32-bit `load_data` with glitch-safe timing. The bank is level-sensitive, so the sequencer pulses `enable` for exactly one cycle per write, keeps `load_data` stable while `enable` is high, and never changes `enable` and `load_data` on the same edge between two different writes. A per-register `pending` scoreboard tells the operand-fetch side which registers have writes outstanding.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `DATA_W`, 32, data width
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_valid`  in  1  write request present
- `wr_ready`  out  1  request can be accepted this cycle
- `wr_addr`  in  4  destination register R0–R15
- `wr_sel`  in  2  source select: 0 `alu_data`, 1 `mem_data`, 2 `imm_data`, 3 `pc_data`
- `alu_data`, `mem_data`, `imm_data`, `pc_data`  in  DATA_W each  candidate load values
- `hold`  in  1  inhibits starting a new drive
- `flush`  in  1  discards queued, not-yet-driven entries
- `enable`  out  16  one-hot register write enable, or all-zero
- `load_data`  out  DATA_W  value for the enabled register
- `pending`  out  16  bit r set while any queued or in-drive write targets Rr
- `level`  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Accept happens on a rising edge when `wr_valid && wr_ready`.
  - On accept, the selected source value is latched together with `wr_addr` into the FIFO tail.
  - Source values are sampled only at accept; later source changes are ignored.
- `wr_ready = (level < DEPTH)`, combinational from the registered occupancy.
  - There is no pass-through when full: a push is refused at `level == DEPTH` even if a pop occurs in the same cycle.
- The drain FSM is registered and has three states: IDLE, DRIVE, GAP.
  - IDLE → DRIVE: when the FIFO is non-empty, `!hold` and `!flush`. The head is popped on that edge, `enable <= 1 << addr` and `load_data <= data`.
  - DRIVE → GAP: unconditional. `enable <= 0` and `load_data` holds its value.
  - GAP → DRIVE: same condition as IDLE → DRIVE. Otherwise GAP → IDLE.
  - In IDLE and GAP, `enable == 0` and `load_data` holds the last driven value.
- `hold` affects only the start of a drive. A DRIVE in progress always completes.
- `flush` takes effect synchronously.
  - Pointers and `level` reset to 0 on the next edge.
  - An entry already in DRIVE still completes.
  - A push in the same cycle as `flush` is dropped, even though `wr_ready` may be 1.
- `pending[r]` is combinational.
  - It is the OR of `(addr == r)` over all valid FIFO entries, plus the DRIVE-state entry while in DRIVE.
  - Multiple queued writes to the same register keep the bit set until the last one leaves DRIVE.
- Simultaneous push and pop: `level` is unchanged and both pointers advance.
- Pointers are `clog2(DEPTH)` bits and wrap modulo DEPTH. `level` counts 0..DEPTH.

## Timing
- Reset values (asynchronous, while `rst_n == 0`):
  - state IDLE, pointers 0, `level` 0, FIFO contents don't-care
  - `enable` 0, `load_data` 0, `pending` 0, `wr_ready` 1
- Latency: request accepted at edge k into an empty FIFO, with IDLE and `!hold` → `enable` is high from edge k+1 to edge k+2.
- `enable` is high for exactly one cycle per write.
- Sustained throughput is one write per 2 cycles: DRIVE, GAP, DRIVE, …
- `load_data` changes only on the edge where `enable` rises. It stays stable through the whole DRIVE cycle and the following GAP/IDLE.
- `pending[r]` rises combinationally in the cycle after the accepting edge. It falls in the cycle after the DRIVE cycle of the last matching write.
- Reset asserted mid-DRIVE: `enable` drops immediately, asynchronously, and the queue is lost.

## Test plan
- Reset, then one request `wr_addr=5`, `wr_sel=1`, `mem_data=32'hDEADBEEF`, `hold=0` → one cycle after accept: `enable=16'h0020`, `load_data=32'hDEADBEEF`; next cycle `enable=0` with `load_data` unchanged; `pending[5]` is set from accept until DRIVE ends.
- Four back-to-back requests to R0..R3 with `hold=1` → `level=4`, `wr_ready=0`, fifth request not accepted; release `hold` → `enable` pulses `0001, 0, 0002, 0, 0004, 0, 0008` on consecutive cycles, in order.
- Two requests to R7 (`imm_data` `0x11`, then `0x22`) → `pending[7]` stays 1 until the second DRIVE completes; drive order is `0x11` then `0x22`.
- `wr_sel` 0/2/3 with distinct source values, sources changed the cycle after accept → driven `load_data` equals the accept-time values.
- Three entries queued, `flush` asserted during the first DRIVE → that DRIVE completes, no further `enable` pulses, `level=0`, `pending=0`.
- `rst_n` pulled low mid-DRIVE with entries queued → `enable=0`, `load_data=0`, `level=0` immediately; no pulses after release until new requests arrive.
